// File: rtl/issue_select_pkg.sv
// Shared issue/fu types (package sys_defs).
// Contents:
//   FU_SELECT       - functional unit a packet is bound to; FU_NONE encodes as zero so
//                     an all-zero packet means "nothing issued".
//   FU_CLASS        - class of unit an RS entry needs (ALU, MULT, BR).
//   ISSUE_FU_PACKET - packet handed from issue to fu.
//   FU_RS_PACKET    - per-unit release bits returned by fu.
//   IDX_*           - bit positions in fu_busy_out ({br,mult1,mult2,alu1,alu2,alu3}).
package sys_defs;

  typedef enum logic [2:0] {
    FU_NONE = 3'd0,
    ALU_1   = 3'd1,
    ALU_2   = 3'd2,
    ALU_3   = 3'd3,
    MULT_1  = 3'd4,
    MULT_2  = 3'd5,
    BRANCH  = 3'd6
  } FU_SELECT;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    MULT = 2'd1,
    BR   = 2'd2
  } FU_CLASS;

  typedef struct packed {
    FU_CLASS    fu_class;
    FU_SELECT   fu_select;
    logic [7:0] tag;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic alu_1;
    logic alu_2;
    logic alu_3;
    logic mult_1;
    logic mult_2;
  } FU_RS_PACKET;

  localparam int IDX_ALU_3  = 0;
  localparam int IDX_ALU_2  = 1;
  localparam int IDX_ALU_1  = 2;
  localparam int IDX_MULT_2 = 3;
  localparam int IDX_MULT_1 = 4;
  localparam int IDX_BR     = 5;

endpackage

// File: rtl/issue_select_rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter. Picks the first asserted request found when
// scanning upward from ptr_i, wrapping from N-1 to 0.
// Ports:
//   req_i   [N]  request vector
//   ptr_i   [PW] index with highest priority this cycle
//   grant_o [N]  one-hot grant (zero when no request)
//   idx_o   [PW] index of the granted request
//   valid_o      a grant was made
module rr_arbiter #(
  parameter int N  = 16,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan from the farthest offset down so the nearest request to ptr_i is the last write.
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        idx_o   = PW'(j);
        valid_o = 1'b1;
      end
    end
    grant_o = '0;
    if (valid_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/issue_select.sv
// issue_select: picks one ready RS entry per cycle, binds it to a free functional unit and
// registers the resulting packet towards fu. Tracks unit occupancy from fu release bits.
// Ports:
//   clock, reset   clock, async active-high reset
//   rs_ready_in    per-entry operands ready/valid
//   rs_pkt_in      per-entry candidate packets (fu_class selects the unit class)
//   fu_rs_in       release bits from fu (alu_1..3, mult_1..2)
//   fu_stall_in    fu completion stall: no issue, output packet and rr pointer hold
//   rs_grant_out   one-hot combinational grant (zero while reset is high)
//   fu_issue_out   registered packet to fu, fu_select names the bound unit
//   fu_busy_out    {br,mult1,mult2,alu1,alu2,alu3} occupancy
module issue_select
  import sys_defs::*;
#(
  parameter int RS_SIZE = 16,
  parameter int BR_LAT  = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [RS_SIZE-1:0]           rs_ready_in,
  input  ISSUE_FU_PACKET [RS_SIZE-1:0] rs_pkt_in,
  input  FU_RS_PACKET                  fu_rs_in,
  input  logic                         fu_stall_in,
  output logic [RS_SIZE-1:0]           rs_grant_out,
  output ISSUE_FU_PACKET               fu_issue_out,
  output logic [5:0]                   fu_busy_out
);

  localparam int PW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CW = (BR_LAT > 0) ? $clog2(BR_LAT + 1) : 1;

  // busy bits use the same positions as fu_busy_out[4:0]
  logic [4:0]     busy_q, busy_d;
  logic [CW-1:0]  br_cnt_q, br_cnt_d;
  logic [PW-1:0]  rr_q, rr_d;
  ISSUE_FU_PACKET issue_q, issue_d;

  logic [4:0]         rel, free, issued;
  logic               alu_free, mult_free, br_free;
  logic [RS_SIZE-1:0] elig, grant;
  logic [PW-1:0]      gidx;
  logic               gvalid;

  assign rel = {fu_rs_in.mult_1, fu_rs_in.mult_2, fu_rs_in.alu_1, fu_rs_in.alu_2, fu_rs_in.alu_3};
  // A unit released this cycle may be issued to in the same cycle.
  assign free      = ~busy_q | rel;
  assign alu_free  = free[IDX_ALU_1] | free[IDX_ALU_2] | free[IDX_ALU_3];
  assign mult_free = free[IDX_MULT_1] | free[IDX_MULT_2];
  assign br_free   = (br_cnt_q == '0);

  always_comb begin
    elig = '0;
    if (!fu_stall_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        case (rs_pkt_in[i].fu_class)
          ALU:     elig[i] = rs_ready_in[i] & alu_free;
          MULT:    elig[i] = rs_ready_in[i] & mult_free;
          BR:      elig[i] = rs_ready_in[i] & br_free;
          default: elig[i] = 1'b0;
        endcase
      end
    end
  end

  rr_arbiter #(.N(RS_SIZE), .PW(PW)) u_arb (
    .req_i   (elig),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .valid_o (gvalid)
  );

  always_comb begin
    issued   = '0;
    issue_d  = issue_q;
    rr_d     = rr_q;
    br_cnt_d = (br_cnt_q != '0) ? br_cnt_q - CW'(1) : br_cnt_q;
    if (!fu_stall_in) begin
      issue_d = '0;  // all-zero packet carries FU_NONE
      if (gvalid) begin
        issue_d = rs_pkt_in[gidx];
        rr_d    = (gidx == PW'(RS_SIZE - 1)) ? '0 : gidx + PW'(1);
        case (issue_d.fu_class)
          ALU: begin
            if (free[IDX_ALU_1]) begin
              issue_d.fu_select = ALU_1;
              issued[IDX_ALU_1] = 1'b1;
            end else if (free[IDX_ALU_2]) begin
              issue_d.fu_select = ALU_2;
              issued[IDX_ALU_2] = 1'b1;
            end else begin
              issue_d.fu_select = ALU_3;
              issued[IDX_ALU_3] = 1'b1;
            end
          end
          MULT: begin
            if (free[IDX_MULT_1]) begin
              issue_d.fu_select  = MULT_1;
              issued[IDX_MULT_1] = 1'b1;
            end else begin
              issue_d.fu_select  = MULT_2;
              issued[IDX_MULT_2] = 1'b1;
            end
          end
          default: begin
            issue_d.fu_select = BRANCH;
            br_cnt_d          = CW'(BR_LAT);
          end
        endcase
      end
    end
    // A new issue wins over a release of the same unit.
    busy_d = (busy_q & ~rel) | issued;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      br_cnt_q <= '0;
      rr_q     <= '0;
      issue_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      br_cnt_q <= br_cnt_d;
      rr_q     <= rr_d;
      issue_q  <= issue_d;
    end
  end

  assign rs_grant_out = reset ? '0 : grant;
  assign fu_issue_out = issue_q;
  assign fu_busy_out  = {~br_free, busy_q};

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: round-robin grant order, unit binding, release bypass,
// stall freeze, pointer wrap, branch occupancy and asynchronous reset.
module tb_issue_select;
  import sys_defs::*;

  logic                  clock;
  logic                  reset;
  logic [15:0]           rs_ready;
  ISSUE_FU_PACKET [15:0] rs_pkt;
  FU_RS_PACKET           fu_rs;
  logic                  fu_stall;
  logic [15:0]           rs_grant;
  ISSUE_FU_PACKET        fu_issue;
  logic [5:0]            fu_busy;

  int checks = 0;
  int errors = 0;

  issue_select #(.RS_SIZE(16), .BR_LAT(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .rs_ready_in  (rs_ready),
    .rs_pkt_in    (rs_pkt),
    .fu_rs_in     (fu_rs),
    .fu_stall_in  (fu_stall),
    .rs_grant_out (rs_grant),
    .fu_issue_out (fu_issue),
    .fu_busy_out  (fu_busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [12:0] pk(input FU_CLASS c, input FU_SELECT s, input int i);
    pk = {c, s, 8'(i + 16)};
  endfunction

  task automatic set_entry(input int i, input FU_CLASS c);
    rs_pkt[i] = {c, FU_NONE, 8'(i + 16)};
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rs_ready = '0;
    fu_rs    = '0;
    fu_stall = 1'b0;
    reset    = 1'b1;
    #2;
    reset    = 1'b0;
  endtask

  task automatic chk_issue(input string name, input logic [12:0] exp);
    chk(name, 32'(fu_issue), 32'(exp));
  endtask

  initial begin
    reset    = 1'b1;
    fu_rs    = '0;
    fu_stall = 1'b0;
    for (int i = 0; i < 16; i++) set_entry(i, ALU);
    rs_ready = 16'h0003;
    #3;
    chk("rst_grant", 32'(rs_grant), 32'h0);
    chk_issue("rst_issue", 13'h0);
    chk("rst_busy", 32'(fu_busy), 32'h0);

    // 1: entries 0,1 ALU -> ALU_1 then ALU_2
    cyc(); reset = 1'b0; #1;
    chk("t1_grant0", 32'(rs_grant), 32'h0001);
    cyc(); rs_ready = 16'h0002; #1;
    chk("t1_grant1", 32'(rs_grant), 32'h0002);
    chk_issue("t1_issue0", pk(ALU, ALU_1, 0));
    chk("t1_busy0", 32'(fu_busy), 32'h04);
    cyc(); rs_ready = 16'h0000; #1;
    chk("t1_grant_none", 32'(rs_grant), 32'h0);
    chk_issue("t1_issue1", pk(ALU, ALU_2, 1));
    chk("t1_busy1", 32'(fu_busy), 32'h06);
    cyc(); fu_rs = 5'b11111; #1;
    chk_issue("t1_issue_idle", 13'h0);
    cyc(); fu_rs = '0; #1;
    chk("t1_busy_released", 32'(fu_busy), 32'h0);
    cyc(); fu_rs = 5'b11111;
    cyc(); fu_rs = '0; #1;
    chk("t1_release_idle_unit", 32'(fu_busy), 32'h0);

    // 2: four ALU entries, three units; bypassed alu_2 release
    do_reset();
    cyc(); rs_ready = 16'h000F; #1;
    chk("t2_g0", 32'(rs_grant), 32'h0001);
    cyc(); rs_ready = 16'h000E; #1;
    chk("t2_g1", 32'(rs_grant), 32'h0002);
    chk_issue("t2_i0", pk(ALU, ALU_1, 0));
    cyc(); rs_ready = 16'h000C; #1;
    chk("t2_g2", 32'(rs_grant), 32'h0004);
    chk_issue("t2_i1", pk(ALU, ALU_2, 1));
    cyc(); rs_ready = 16'h0008; #1;
    chk("t2_full_wait", 32'(rs_grant), 32'h0);
    chk_issue("t2_i2", pk(ALU, ALU_3, 2));
    chk("t2_busy_full", 32'(fu_busy), 32'h07);
    cyc(); #1;
    chk("t2_still_wait", 32'(rs_grant), 32'h0);
    chk_issue("t2_idle", 13'h0);
    cyc(); fu_rs.alu_2 = 1'b1; #1;
    chk("t2_bypass_grant", 32'(rs_grant), 32'h0008);
    cyc(); rs_ready = '0; fu_rs = '0; #1;
    chk_issue("t2_i3", pk(ALU, ALU_2, 3));
    chk("t2_busy_after", 32'(fu_busy), 32'h07);

    // 3: MULT entries 3,5,7
    do_reset();
    for (int i = 0; i < 16; i++) set_entry(i, MULT);
    cyc(); rs_ready = 16'h00A8; #1;
    chk("t3_g3", 32'(rs_grant), 32'h0008);
    cyc(); rs_ready = 16'h00A0; #1;
    chk("t3_g5", 32'(rs_grant), 32'h0020);
    chk_issue("t3_i3", pk(MULT, MULT_1, 3));
    cyc(); rs_ready = 16'h0080; #1;
    chk("t3_wait7", 32'(rs_grant), 32'h0);
    chk_issue("t3_i5", pk(MULT, MULT_2, 5));
    chk("t3_busy", 32'(fu_busy), 32'h18);
    cyc(); fu_rs.mult_1 = 1'b1; #1;
    chk("t3_g7", 32'(rs_grant), 32'h0080);
    cyc(); rs_ready = '0; fu_rs = '0; #1;
    chk_issue("t3_i7", pk(MULT, MULT_1, 7));
    chk("t3_busy_after", 32'(fu_busy), 32'h18);

    // 4: stall for three cycles
    do_reset();
    for (int i = 0; i < 16; i++) set_entry(i, ALU);
    cyc(); rs_ready = 16'h0004; #1;
    chk("t4_g2", 32'(rs_grant), 32'h0004);
    cyc(); rs_ready = 16'h0003; fu_stall = 1'b1; fu_rs.alu_1 = 1'b1; #1;
    chk("t4_stall_g_a", 32'(rs_grant), 32'h0);
    chk_issue("t4_stall_i_a", pk(ALU, ALU_1, 2));
    chk("t4_busy_a", 32'(fu_busy), 32'h04);
    cyc(); fu_rs = '0; #1;
    chk("t4_stall_g_b", 32'(rs_grant), 32'h0);
    chk_issue("t4_stall_i_b", pk(ALU, ALU_1, 2));
    chk("t4_busy_cleared", 32'(fu_busy), 32'h0);
    cyc(); #1;
    chk("t4_stall_g_c", 32'(rs_grant), 32'h0);
    chk_issue("t4_stall_i_c", pk(ALU, ALU_1, 2));
    cyc(); fu_stall = 1'b0; #1;
    chk("t4_resume_g0", 32'(rs_grant), 32'h0001);
    cyc(); rs_ready = 16'h0002; #1;
    chk("t4_resume_g1", 32'(rs_grant), 32'h0002);
    chk_issue("t4_i0", pk(ALU, ALU_1, 0));
    cyc(); rs_ready = '0; #1;
    chk_issue("t4_i1", pk(ALU, ALU_2, 1));

    // 5: pointer wrap 15 -> 0
    do_reset();
    cyc(); rs_ready = 16'h4000; #1;
    chk("t5_g14", 32'(rs_grant), 32'h4000);
    cyc(); rs_ready = 16'h8001; #1;
    chk("t5_g15", 32'(rs_grant), 32'h8000);
    chk_issue("t5_i14", pk(ALU, ALU_1, 14));
    cyc(); rs_ready = 16'h0001; #1;
    chk("t5_g0", 32'(rs_grant), 32'h0001);
    chk_issue("t5_i15", pk(ALU, ALU_2, 15));
    cyc(); rs_ready = '0; #1;
    chk_issue("t5_i0", pk(ALU, ALU_3, 0));

    // 6: branches with BR_LAT=1, then reset mid-stream
    do_reset();
    set_entry(0, BR);
    set_entry(1, BR);
    set_entry(2, ALU);
    cyc(); rs_ready = 16'h0003; #1;
    chk("t6_g0", 32'(rs_grant), 32'h0001);
    cyc(); rs_ready = 16'h0002; #1;
    chk("t6_br_busy_wait", 32'(rs_grant), 32'h0);
    chk_issue("t6_i0", pk(BR, BRANCH, 0));
    chk("t6_busy_br", 32'(fu_busy), 32'h20);
    cyc(); #1;
    chk("t6_g1", 32'(rs_grant), 32'h0002);
    chk_issue("t6_idle", 13'h0);
    chk("t6_busy_free", 32'(fu_busy), 32'h0);
    cyc(); rs_ready = 16'h0004; #1;
    chk("t6_g2", 32'(rs_grant), 32'h0004);
    chk_issue("t6_i1", pk(BR, BRANCH, 1));
    chk("t6_busy_br2", 32'(fu_busy), 32'h20);
    reset = 1'b1; #1;
    chk("t6_rst_grant", 32'(rs_grant), 32'h0);
    chk_issue("t6_rst_issue", 13'h0);
    chk("t6_rst_busy", 32'(fu_busy), 32'h0);
    rs_ready = '0;
    #1 reset = 1'b0;
    cyc(); #1;
    chk_issue("t6_post_rst_issue", 13'h0);
    chk("t6_post_rst_busy", 32'(fu_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
